pc_seq_ctrl: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the 8-bit program counter datapath. It fetches an instruction at the current PC from instruction memory using a req/ack handshake, then decodes it. It drives the PC's step, branch and offset controls, and issues one execute pulse per ALU instruction. It sits between the PC register, instruction memory and the ALU control.

---
 rtl/pc_seq_pkg.sv | 31 +++
 rtl/pc_seq_decode.sv | 37 +++
 rtl/pc_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// ============================================================
// pc_seq_pkg : shared state encoding, opcodes and offset helper
//              for the pc_seq_ctrl sequencer.
// Rev 1.0
// ============================================================
`default_nettype none

package pc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4,
    FAULT  = 3'd5
  } state_e;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_BRZ  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  // Widened to 32 bits so any address width can take its low slice.
  function automatic logic [31:0] sext_off(input logic [5:0] off);
    return {{26{off[5]}}, off};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_seq_decode.sv
// ============================================================
// pc_seq_decode : combinational instruction decode for pc_seq_ctrl.
// Rev 1.0
// ============================================================
`default_nettype none

module pc_seq_decode
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
) (
  input  logic [INSTR_W-1:0] ir_i,
  input  logic               zero_flag_i,
  output logic               is_halt_o,
  output logic               branch_taken_o,
  output logic [ADDR_W-1:0]  offset_ext_o,
  output logic               is_alu_o
);

  logic [1:0]  op;
  logic [31:0] ext;
  logic        unused_ext_hi;

  assign op  = ir_i[INSTR_W-1 -: 2];
  assign ext = sext_off(ir_i[5:0]);

  assign is_halt_o      = (op == OP_HALT);
  assign is_alu_o       = (op == OP_ALU);
  assign branch_taken_o = (op == OP_BR) | ((op == OP_BRZ) & zero_flag_i);
  assign offset_ext_o   = ext[ADDR_W-1:0];

  assign unused_ext_hi  = ^ext[31:ADDR_W];

endmodule

`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
// ============================================================
// pc_seq_ctrl : fetch/decode/execute sequencer for the 8-bit PC datapath.
// Optional FETCH ack timeout enabled by defining PC_SEQ_TIMEOUT_EN.
// Rev 1.0
// ============================================================
`default_nettype none

module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc_value,
  input  logic               zero_flag,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               pc_step,
  output logic               pc_branch,
  output logic [ADDR_W-1:0]  pc_offset,
  output logic               exec_pulse,
  output logic [INSTR_W-1:0] ir,
  output logic               busy,
  output logic               halted,
  output logic               fault
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  offset_q, offset_d;
  logic               branch_q, branch_d;

  logic               dec_halt, dec_taken, dec_alu;
  logic [ADDR_W-1:0]  dec_off;
  logic [ADDR_W-1:0]  next_pc;
  logic               fetch_timeout;

  pc_seq_decode #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_decode (
    .ir_i           (ir_q),
    .zero_flag_i    (zero_flag),
    .is_halt_o      (dec_halt),
    .branch_taken_o (dec_taken),
    .offset_ext_o   (dec_off),
    .is_alu_o       (dec_alu)
  );

  // offset_q is zero for untaken branches, so one adder covers both cases.
  assign next_pc = pc_value + offset_q + ADDR_W'(1);

`ifdef PC_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs in FETCH, so it is already zero on every FETCH entry.
  assign cnt_d         = (state_q == FETCH) ? cnt_q + CNT_W'(1) : '0;
  assign fetch_timeout = (state_q == FETCH) && (cnt_q == TO_VAL - CNT_W'(1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fault = (state_q == FAULT);
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign fetch_timeout  = 1'b0;
  assign fault          = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      addr_q   <= '0;
      offset_q <= '0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      addr_q   <= addr_d;
      offset_q <= offset_d;
      branch_q <= branch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    addr_d   = addr_q;
    offset_d = offset_q;
    branch_d = branch_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = pc_value;
        end
      end
      FETCH: begin
        // An ack coinciding with the timeout still completes the fetch.
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = DECODE;
        end else if (fetch_timeout) begin
          state_d = FAULT;
        end
      end
      DECODE: begin
        if (dec_halt) begin
          state_d  = HALT;
          branch_d = 1'b0;
          offset_d = '0;
        end else begin
          state_d  = EXEC;
          branch_d = dec_taken;
          offset_d = dec_taken ? dec_off : '0;
        end
      end
      EXEC: begin
        branch_d = 1'b0;
        offset_d = '0;
        if (start) begin
          state_d = FETCH;
          addr_d  = next_pc;
        end else begin
          state_d = IDLE;
        end
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = addr_q;
  assign pc_step    = (state_q == EXEC);
  assign pc_branch  = branch_q;
  assign pc_offset  = offset_q;
  assign exec_pulse = (state_q == EXEC) & dec_alu;
  assign ir         = ir_q;
  assign busy       = (state_q == FETCH) | (state_q == DECODE) | (state_q == EXEC);
  assign halted     = (state_q == HALT);

endmodule

`default_nettype wire

// File: tb/tb_pc_seq_ctrl.sv
// ============================================================
// tb_pc_seq_ctrl : directed self-checking bench for pc_seq_ctrl.
// Rev 1.0
// ============================================================
`default_nettype none

module tb_pc_seq_ctrl;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pc_value = 8'h00;
  logic       zero_flag = 1'b0;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;

  logic       imem_req, pc_step, pc_branch, exec_pulse, busy, halted, fault;
  logic [7:0] imem_addr, pc_offset, ir;

  int total = 0;
  int bad   = 0;

  pc_seq_ctrl dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .pc_value   (pc_value),
    .zero_flag  (zero_flag),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .pc_step    (pc_step),
    .pc_branch  (pc_branch),
    .pc_offset  (pc_offset),
    .exec_pulse (exec_pulse),
    .ir         (ir),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    clr_n     = 1'b0;
    start     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    zero_flag = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  // Waits for a request, acks it at once, then samples the cycle after
  // DECODE (EXEC slot) and the cycle after that (next-fetch slot).
  task automatic do_instr(input logic [7:0] data, output logic ok,
                          output logic step, output logic br, output logic [7:0] off,
                          output logic ex, output logic bz, output logic hl,
                          output logic [7:0] naddr, output logic nreq);
    ok = 1'b0; step = 1'b0; br = 1'b0; off = 8'h00; ex = 1'b0;
    bz = 1'b0; hl = 1'b0; naddr = 8'h00; nreq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      imem_ack  = 1'b1;
      imem_data = data;
      @(negedge clk);
      imem_ack  = 1'b0;
      imem_data = 8'h00;
      @(negedge clk);
      step = pc_step; br = pc_branch; off = pc_offset; ex = exec_pulse;
      bz = busy; hl = halted;
      @(negedge clk);
      naddr = imem_addr; nreq = imem_req;
    end
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    total++;
    if ({imem_req, busy, pc_step, exec_pulse, halted, fault, pc_branch} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {imem_req, busy, pc_step, exec_pulse, halted, fault, pc_branch});
    end
    total++;
    if ({ir, imem_addr, pc_offset} !== 24'h0) begin
      bad++;
      $display("FAIL reset_regs got=%h exp=000000", {ir, imem_addr, pc_offset});
    end
    clr_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got=%b%b exp=00", busy, imem_req);
    end
  endtask

  task automatic test_alu_latency;
    logic ok;
    do_reset;
    pc_value = 8'h10;
    start    = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok || imem_addr !== 8'h10) begin
      bad++;
      $display("FAIL alu_fetch_addr got=%h req=%b exp=10", imem_addr, ok);
    end
    imem_ack  = 1'b1;
    imem_data = 8'h00;
    @(negedge clk);
    imem_ack = 1'b0;
    total++;
    if (imem_req !== 1'b0 || pc_step !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL alu_decode_slot got=req%b step%b busy%b exp=req0 step0 busy1",
               imem_req, pc_step, busy);
    end
    @(negedge clk);
    total++;
    if (pc_step !== 1'b1 || exec_pulse !== 1'b1 || pc_branch !== 1'b0) begin
      bad++;
      $display("FAIL alu_exec got=step%b ex%b br%b exp=step1 ex1 br0",
               pc_step, exec_pulse, pc_branch);
    end
    @(negedge clk);
    total++;
    if (imem_addr !== 8'h11 || imem_req !== 1'b1 || pc_step !== 1'b0) begin
      bad++;
      $display("FAIL alu_next_addr got=%h req=%b step=%b exp=11 req=1 step=0",
               imem_addr, imem_req, pc_step);
    end
  endtask

  task automatic test_brz;
    logic ok, step, br, ex, bz, hl, nreq;
    logic [7:0] off, naddr;
    pc_value  = 8'h20;
    zero_flag = 1'b1;
    do_instr(8'h45, ok, step, br, off, ex, bz, hl, naddr, nreq);
    total++;
    if (!ok || step !== 1'b1 || br !== 1'b1 || off !== 8'h05 || ex !== 1'b0) begin
      bad++;
      $display("FAIL brz_taken got=ok%b step%b br%b off%h ex%b exp=ok1 step1 br1 off05 ex0",
               ok, step, br, off, ex);
    end
    total++;
    if (naddr !== 8'h26 || nreq !== 1'b1) begin
      bad++;
      $display("FAIL brz_taken_next got=%h req%b exp=26 req1", naddr, nreq);
    end
    zero_flag = 1'b0;
    do_instr(8'h45, ok, step, br, off, ex, bz, hl, naddr, nreq);
    total++;
    if (!ok || step !== 1'b1 || br !== 1'b0 || off !== 8'h00) begin
      bad++;
      $display("FAIL brz_not_taken got=ok%b step%b br%b off%h exp=ok1 step1 br0 off00",
               ok, step, br, off);
    end
    total++;
    if (naddr !== 8'h21) begin
      bad++;
      $display("FAIL brz_not_taken_next got=%h exp=21", naddr);
    end
  endtask

  task automatic test_br_wrap;
    logic ok, step, br, ex, bz, hl, nreq;
    logic [7:0] off, naddr;
    pc_value = 8'h02;
    do_instr(8'hBC, ok, step, br, off, ex, bz, hl, naddr, nreq);
    total++;
    if (!ok || br !== 1'b1 || off !== 8'hFC || naddr !== 8'hFF) begin
      bad++;
      $display("FAIL br_negative got=ok%b br%b off%h next%h exp=ok1 br1 offfc nextff",
               ok, br, off, naddr);
    end
    pc_value = 8'hFF;
    do_instr(8'h00, ok, step, br, off, ex, bz, hl, naddr, nreq);
    total++;
    if (!ok || ex !== 1'b1 || br !== 1'b0 || naddr !== 8'h00) begin
      bad++;
      $display("FAIL alu_wrap got=ok%b ex%b br%b next%h exp=ok1 ex1 br0 next00",
               ok, ex, br, naddr);
    end
  endtask

  task automatic test_start_drop;
    logic ok, step, br, ex, bz, hl, nreq;
    logic [7:0] off, naddr;
    pc_value = 8'h40;
    start    = 1'b0;
    do_instr(8'h01, ok, step, br, off, ex, bz, hl, naddr, nreq);
    total++;
    if (!ok || step !== 1'b1 || ex !== 1'b1 || nreq !== 1'b0 || busy !== 1'b0 || ir !== 8'h01) begin
      bad++;
      $display("FAIL start_drop got=ok%b step%b ex%b req%b busy%b ir%h exp=ok1 step1 ex1 req0 busy0 ir01",
               ok, step, ex, nreq, busy, ir);
    end
    pc_value = 8'h55;
    start    = 1'b1;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h55) begin
      bad++;
      $display("FAIL restart_addr got=req%b addr%h exp=req1 addr55", imem_req, imem_addr);
    end
  endtask

  task automatic test_halt;
    logic ok, step, br, ex, bz, hl, nreq;
    logic [7:0] off, naddr;
    int req_seen;
    do_instr(8'hC0, ok, step, br, off, ex, bz, hl, naddr, nreq);
    total++;
    if (!ok || step !== 1'b0 || hl !== 1'b1 || bz !== 1'b0 || ex !== 1'b0) begin
      bad++;
      $display("FAIL halt_entry got=ok%b step%b halted%b busy%b ex%b exp=ok1 step0 halted1 busy0 ex0",
               ok, step, hl, bz, ex);
    end
    req_seen = 0;
    for (int i = 0; i < 12; i++) begin
      start = ~start;
      @(negedge clk);
      if (imem_req !== 1'b0 || pc_step !== 1'b0) req_seen++;
    end
    total++;
    if (req_seen != 0 || halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_sticky got=reqs%0d halted%b exp=reqs0 halted1", req_seen, halted);
    end
    clr_n = 1'b0;
    #1;
    total++;
    if (halted !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL halt_clear got=halted%b busy%b exp=halted0 busy0", halted, busy);
    end
    start = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_reset_midfetch;
    logic ok, step, br, ex, bz, hl, nreq;
    logic [7:0] off, naddr;
    pc_value = 8'h30;
    start    = 1'b1;
    do_instr(8'h15, ok, step, br, off, ex, bz, hl, naddr, nreq);
    total++;
    if (!ok || nreq !== 1'b1 || ir !== 8'h15 || naddr !== 8'h31) begin
      bad++;
      $display("FAIL midfetch_setup got=ok%b req%b ir%h next%h exp=ok1 req1 ir15 next31",
               ok, nreq, ir, naddr);
    end
    #2;
    clr_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || ir !== 8'h00 || imem_addr !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_clear got=req%b ir%h addr%h busy%b exp=req0 ir00 addr00 busy0",
               imem_req, ir, imem_addr, busy);
    end
    start = 1'b0;
    @(negedge clk);
    clr_n     = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 8'hAA;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    @(negedge clk);
    total++;
    if (ir !== 8'h00 || busy !== 1'b0 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL stray_ack got=ir%h busy%b req%b exp=ir00 busy0 req0", ir, busy, imem_req);
    end
  endtask

  task automatic test_timeout;
    int n;
    logic ok;
    do_reset;
    start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
`ifdef PC_SEQ_TIMEOUT_EN
    n = ok ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b1) break;
      n++;
    end
    total++;
    if (n != 15 || fault !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_fault got=cycles%0d fault%b req%b busy%b exp=cycles15 fault1 req0 busy0",
               n, fault, imem_req, busy);
    end
    repeat (4) begin
      start = ~start;
      @(negedge clk);
    end
    total++;
    if (fault !== 1'b1 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL fault_sticky got=fault%b req%b exp=fault1 req0", fault, imem_req);
    end
    do_reset;
    start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (14) @(negedge clk);
    total++;
    if (!ok || imem_req !== 1'b1 || fault !== 1'b0) begin
      bad++;
      $display("FAIL timeout_cycle15 got=ok%b req%b fault%b exp=ok1 req1 fault0", ok, imem_req, fault);
    end
    imem_ack  = 1'b1;
    imem_data = 8'h02;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    total++;
    if (fault !== 1'b0 || busy !== 1'b1 || ir !== 8'h02 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL ack_wins got=fault%b busy%b ir%h req%b exp=fault0 busy1 ir02 req0",
               fault, busy, ir, imem_req);
    end
`else
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && fault === 1'b0) n++;
    end
    total++;
    if (!ok || n != 100 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stall_no_fault got=ok%b cycles%0d busy%b exp=ok1 cycles100 busy1", ok, n, busy);
    end
`endif
    do_reset;
  endtask

  initial begin
    test_reset;
    test_alu_latency;
    test_brz;
    test_br_wrap;
    test_start_drop;
    test_halt;
    test_reset_midfetch;
    test_timeout;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
